// File: rtl/vend_change_if.sv
// Coin-side and hopper-side handshake bundle for the vending controller.
// master drives coins, cancel and change_ack; slave is the controller.
interface vend_change_if #(
    parameter int AMT_W = 6,
    parameter int CNT_W = 3
);
    logic             coin_valid;
    logic [AMT_W-1:0] coin_amt;
    logic             coin_ready;
    logic             cancel;
    logic             coin_reject;
    logic             coffee;
    logic             change_valid;
    logic [AMT_W-1:0] change_amt;
    logic             change_ack;
    logic [AMT_W-1:0] credit;
    logic [CNT_W-1:0] count;
    logic             busy;

    modport master (
        output coin_valid, coin_amt, cancel, change_ack,
        input  coin_ready, coin_reject, coffee, change_valid, change_amt,
               credit, count, busy
    );

    modport slave (
        input  coin_valid, coin_amt, cancel, change_ack,
        output coin_ready, coin_reject, coffee, change_valid, change_amt,
               credit, count, busy
    );
endinterface

// File: rtl/vend_change_fsm.sv
// Coffee vending controller: accumulates coin credit, vends at PRICE, pays change,
// refunds on cancel, rejects overflowing coins and counts cups (saturating).
module vend_change_fsm #(
    parameter int AMT_W      = 6,
    parameter int PRICE      = 20,
    parameter int MAX_CREDIT = 63,
    parameter int CNT_W      = 3
) (
    input logic         clk,
    input logic         rst,
    vend_change_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam logic [AMT_W-1:0] PRICE_A = AMT_W'(PRICE);
    localparam logic [AMT_W:0]   MAX_X   = (AMT_W+1)'(MAX_CREDIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state, w_state_nxt;
    logic [AMT_W-1:0] r_credit, w_credit_nxt;
    logic [AMT_W-1:0] r_change_amt, w_change_amt_nxt;
    logic             r_change_valid, w_change_valid_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_coffee, w_coffee_nxt;
    logic             r_coin_reject, w_coin_reject_nxt;

    logic             w_coin_ready;
    logic             w_accept;
    logic             w_fits;
    logic [AMT_W:0]   w_sum;

    assign w_coin_ready = ((r_state == S_IDLE) || (r_state == S_COLLECT)) && (r_credit < PRICE_A);
    assign w_accept     = bus.coin_valid && w_coin_ready && (bus.coin_amt != '0);
    // One extra bit so an overflowing sum is seen rather than wrapped.
    assign w_sum        = {1'b0, r_credit} + {1'b0, bus.coin_amt};
    assign w_fits       = (w_sum <= MAX_X);

    always_comb begin
        // NOTE: every next-value signal gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_state_nxt        = r_state;
        w_credit_nxt       = r_credit;
        w_change_amt_nxt   = r_change_amt;
        w_change_valid_nxt = r_change_valid;
        w_count_nxt        = r_count;
        w_coffee_nxt       = 1'b0;
        w_coin_reject_nxt  = w_accept && !w_fits;

        case (r_state)
            S_IDLE: begin
                if (w_accept && w_fits) begin
                    w_credit_nxt = w_sum[AMT_W-1:0];
                    w_state_nxt  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.cancel) begin
                    w_change_amt_nxt   = (w_accept && w_fits) ? w_sum[AMT_W-1:0] : r_credit;
                    w_change_valid_nxt = 1'b1;
                    w_credit_nxt       = '0;
                    w_state_nxt        = S_CHANGE;
                end else if (r_credit >= PRICE_A) begin
                    w_state_nxt = S_VEND;
                end else if (w_accept && w_fits) begin
                    w_credit_nxt = w_sum[AMT_W-1:0];
                end
            end
            S_VEND: begin
                w_coffee_nxt = 1'b1;
                w_credit_nxt = '0;
                if (r_count != CNT_MAX) begin
                    w_count_nxt = r_count + 1'b1;
                end
                if (r_credit > PRICE_A) begin
                    w_change_amt_nxt   = r_credit - PRICE_A;
                    w_change_valid_nxt = 1'b1;
                    w_state_nxt        = S_CHANGE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (bus.change_ack) begin
                    w_change_amt_nxt   = '0;
                    w_change_valid_nxt = 1'b0;
                    w_state_nxt        = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_change_amt   <= '0;
            r_change_valid <= 1'b0;
            r_count        <= '0;
            r_coffee       <= 1'b0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_credit       <= w_credit_nxt;
            r_change_amt   <= w_change_amt_nxt;
            r_change_valid <= w_change_valid_nxt;
            r_count        <= w_count_nxt;
            r_coffee       <= w_coffee_nxt;
            r_coin_reject  <= w_coin_reject_nxt;
        end
    end

    assign bus.coin_ready   = w_coin_ready;
    assign bus.coin_reject  = r_coin_reject;
    assign bus.coffee       = r_coffee;
    assign bus.change_valid = r_change_valid;
    assign bus.change_amt   = r_change_amt;
    assign bus.credit       = r_credit;
    assign bus.count        = r_count;
    assign bus.busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
endmodule
